// File: rtl/cook_program_sequencer.sv
// Multi-stage microwave cooking sequencer: collects M:SS/power stages from the
// keypad into a small FIFO, loads each into the external BCD countdown timer,
// paces its decrement once per second and duty-cycles the magnetron by power.
module cook_program_sequencer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int QUEUE_DEPTH   = 4,
    parameter int BEEP_SECS     = 3
) (
    input  logic                         clock,
    input  logic                         clearn,
    input  logic [9:0]                   key,
    input  logic [3:0]                   power_sel,
    input  logic                         enter_stagen,
    input  logic                         startn,
    input  logic                         stopn,
    input  logic                         door_closed,
    input  logic                         timer_zero,
    output logic                         timer_load,
    output logic [3:0]                   timer_min,
    output logic [3:0]                   timer_tens,
    output logic [3:0]                   timer_ones,
    output logic                         timer_dec,
    output logic                         mag_on,
    output logic                         beep,
    output logic [1:0]                   stage_idx,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         push_err
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TICKS_PER_SEC + 1);
    localparam int BW = $clog2(BEEP_SECS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COOK, S_PAUSE, S_DONE} state_t;

    state_t          state, state_next;
    logic [9:0]      key_r;
    logic            enter_r, start_r, stop_r;
    logic [3:0]      entry_min, entry_tens, entry_ones;
    logic [3:0]      q_min [QUEUE_DEPTH];
    logic [3:0]      q_tens[QUEUE_DEPTH];
    logic [3:0]      q_ones[QUEUE_DEPTH];
    logic [3:0]      q_pwr [QUEUE_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [TW-1:0]   presc;
    logic [3:0]      win;
    logic [BW-1:0]   beep_cnt;

    logic [9:0]      key_rise;
    logic            digit_edge, enter_edge, start_edge, stop_edge;
    logic [3:0]      digit, power_eff, push_pwr;
    logic            entry_zero, full, tick, auto_push;
    logic            do_push, do_pop, do_flush, clr_entry, do_shift, err;
    logic            clr_cnt, run, beep_run, idx_clr;

    // Edge detection: every button acts once on its assert edge only.
    assign key_rise   = key & ~key_r;
    assign digit_edge = $onehot(key) && (key_rise != 10'd0);
    assign enter_edge = ~enter_stagen & enter_r;
    assign start_edge = ~startn & start_r;
    assign stop_edge  = ~stopn & stop_r;

    assign entry_zero = ({entry_min, entry_tens, entry_ones} == 12'd0);
    assign full       = (queue_count == CW'(QUEUE_DEPTH));
    assign tick       = (presc == TW'(TICKS_PER_SEC - 1));
    assign power_eff  = (power_sel >= 4'd1 && power_sel <= 4'd10) ? power_sel : 4'd10;

    // Decode the single pressed digit key to its value.
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 10; i++)
            if (key[i]) digit = 4'(i);
    end

    // Remember previous button levels for edge detection.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            key_r   <= '0;
            enter_r <= 1'b1;
            start_r <= 1'b1;
            stop_r  <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            key_r   <= key;
            enter_r <= enter_stagen;
            start_r <= startn;
            stop_r  <= stopn;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state and control decode, highest-priority event first.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_next = state;
        do_push    = 1'b0;
        push_pwr   = power_eff;
        auto_push  = 1'b0;
        do_pop     = 1'b0;
        do_flush   = 1'b0;
        clr_entry  = 1'b0;
        do_shift   = 1'b0;
        err        = 1'b0;
        clr_cnt    = 1'b0;
        run        = 1'b0;
        beep_run   = 1'b0;
        idx_clr    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (stop_edge) begin
                    clr_entry = 1'b1;
                end else if (start_edge) begin
                    auto_push = (queue_count == '0) && !entry_zero;
                    if (auto_push) begin
                        do_push   = 1'b1;
                        push_pwr  = 4'd10;
                        clr_entry = 1'b1;
                    end
                    if ((queue_count != '0 || auto_push) && door_closed) begin
                        state_next = S_LOAD;
                        idx_clr    = 1'b1;
                    end
                end else if (enter_edge) begin
                    if (full || entry_zero) err = 1'b1;
                    else begin
                        do_push   = 1'b1;
                        clr_entry = 1'b1;
                    end
                end else if (digit_edge) begin
                    do_shift = 1'b1;
                end
            end
            S_LOAD: begin
                clr_cnt    = 1'b1;
                state_next = S_COOK;
            end
            S_COOK: begin
                if (timer_zero) begin
                    do_pop     = 1'b1;
                    clr_cnt    = 1'b1;
                    state_next = (queue_count == CW'(1)) ? S_DONE : S_LOAD;
                end else if (!door_closed || stop_edge) begin
                    state_next = S_PAUSE;
                end else begin
                    run = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_edge) begin
                    do_flush   = 1'b1;
                    clr_entry  = 1'b1;
                    state_next = S_IDLE;
                end else if (start_edge && door_closed) begin
                    state_next = S_COOK;
                end
            end
            S_DONE: begin
                if (start_edge || stop_edge || key_rise != 10'd0) begin
                    state_next = S_IDLE;
                end else begin
                    beep_run = 1'b1;
                    if (tick && beep_cnt == BW'(BEEP_SECS - 1)) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Keypad entry register: BCD shift-in, cleared on push or flush.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            entry_min  <= '0;
            entry_tens <= '0;
            entry_ones <= '0;
        end else if (clr_entry) begin
            entry_min  <= '0;
            entry_tens <= '0;
            entry_ones <= '0;
        end else if (do_shift) begin
            entry_min  <= entry_tens;
            entry_tens <= entry_ones;
            entry_ones <= digit;
        end
    end

    // Stage storage; contents are only meaningful below queue_count.
    // NOTE: the storage array has no reset; empty pointers/count make stale contents unobservable.
    always_ff @(posedge clock) begin
        if (do_push) begin
            q_min[tail]  <= entry_min;
            q_tens[tail] <= entry_tens;
            q_ones[tail] <= entry_ones;
            q_pwr[tail]  <= push_pwr;
        end
    end

    // FIFO pointers, occupancy, completed-stage index and push error pulse.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            head        <= '0;
            tail        <= '0;
            queue_count <= '0;
            stage_idx   <= '0;
            push_err    <= 1'b0;
        end else begin
            push_err <= err;
            if (do_flush) begin
                head        <= '0;
                tail        <= '0;
                queue_count <= '0;
            end else if (do_push) begin
                tail        <= tail + 1'b1;
                queue_count <= queue_count + 1'b1;
            end else if (do_pop) begin
                head        <= head + 1'b1;
                queue_count <= queue_count - 1'b1;
            end
            if (idx_clr)     stage_idx <= '0;
            else if (do_pop) stage_idx <= stage_idx + 1'b1;
        end
    end

    // Second prescaler, power window and beep-duration counters.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            presc    <= '0;
            win      <= '0;
            beep_cnt <= '0;
        end else if (clr_cnt) begin
            presc    <= '0;
            win      <= '0;
            beep_cnt <= '0;
        end else if (run || beep_run) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && run)      win      <= (win == 4'd9) ? 4'd0 : win + 4'd1;
            if (tick && beep_run) beep_cnt <= beep_cnt + 1'b1;
        end
    end

    // Outputs: entry shown while idle, head stage otherwise; magnetron gated by the live door input.
    always_comb begin
        timer_load = (state == S_LOAD);
        timer_dec  = run && tick;
        beep       = (state == S_DONE);
        mag_on     = (state == S_COOK) && door_closed && !timer_zero && (win < q_pwr[head]);
        if (state == S_IDLE) begin
            timer_min  = entry_min;
            timer_tens = entry_tens;
            timer_ones = entry_ones;
        end else begin
            timer_min  = q_min[head];
            timer_tens = q_tens[head];
            timer_ones = q_ones[head];
        end
    end

endmodule

// File: tb/tb_cook_program_sequencer.sv
// Directed bench for cook_program_sequencer: single programs, power duty cycle,
// multi-stage chaining, door/stop/start handling, queue limits and reset.
module tb_cook_program_sequencer;

    logic       clock = 1'b0;
    logic       clearn;
    logic [9:0] key;
    logic [3:0] power_sel;
    logic       enter_stagen, startn, stopn, door_closed, timer_zero;
    logic       timer_load, timer_dec, mag_on, beep, push_err;
    logic [3:0] timer_min, timer_tens, timer_ones;
    logic [1:0] stage_idx;
    logic [2:0] queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    cook_program_sequencer #(.TICKS_PER_SEC(100), .QUEUE_DEPTH(4), .BEEP_SECS(3)) dut (
        .clock(clock), .clearn(clearn), .key(key), .power_sel(power_sel),
        .enter_stagen(enter_stagen), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_load(timer_load), .timer_min(timer_min), .timer_tens(timer_tens),
        .timer_ones(timer_ones), .timer_dec(timer_dec), .mag_on(mag_on), .beep(beep),
        .stage_idx(stage_idx), .queue_count(queue_count), .push_err(push_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each press holds the input for one clock, then releases it at the next falling edge.
    task automatic press_key(input int d);
        @(negedge clock); key = 10'(1 << d);
        @(negedge clock); key = '0;
    endtask
    task automatic press_enter();
        @(negedge clock); enter_stagen = 1'b0;
        @(negedge clock); enter_stagen = 1'b1;
    endtask
    task automatic press_start();
        @(negedge clock); startn = 1'b0;
        @(negedge clock); startn = 1'b1;
    endtask
    task automatic press_stop();
        @(negedge clock); stopn = 1'b0;
        @(negedge clock); stopn = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int first_dec, decs, offs, ons, bad, beeps;
        logic exp_mag;
        clearn = 1'b0; key = '0; power_sel = 4'd10; enter_stagen = 1'b1;
        startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; timer_zero = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_timer_load", timer_load, 0);
        check("rst_mag_on", mag_on, 0);
        check("rst_beep", beep, 0);
        check("rst_queue_count", queue_count, 0);
        check("rst_timer_bcd", {timer_min, timer_tens, timer_ones}, 0);
        clearn = 1'b1;

        // Program 1: 1:00 at power 10
        press_key(1); press_key(0); press_key(0);
        check("t1_entry", {timer_min, timer_tens, timer_ones}, 12'h100);
        press_enter();
        check("t1_qcount", queue_count, 1);
        check("t1_push_err", push_err, 0);
        check("t1_entry_cleared", {timer_min, timer_tens, timer_ones}, 0);
        press_start();
        check("t1_load", timer_load, 1);
        check("t1_load_val", {timer_min, timer_tens, timer_ones}, 12'h100);
        first_dec = -1; decs = 0; offs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (timer_dec) begin
                if (first_dec < 0) first_dec = i;
                decs++;
            end
            if (!mag_on) offs++;
        end
        check("t1_first_dec_cycle", first_dec, 99);
        check("t1_dec_count", decs, 3);
        check("t1_mag_off_cycles", offs, 0);
        @(negedge clock); timer_zero = 1'b1; #1;
        check("t1_mag_off_at_zero", mag_on, 0);
        @(negedge clock); timer_zero = 1'b0;
        check("t1_done_beep", beep, 1);
        check("t1_stage_idx", stage_idx, 1);
        check("t1_qcount_empty", queue_count, 0);
        beeps = 0;
        for (int i = 0; i < 400 && beep; i++) begin
            beeps++;
            @(negedge clock);
        end
        check("t1_beep_cycles", beeps, 300);
        check("t1_idle_after_beep", beep, 0);

        // Program 2: 0:20 at power 3, 3-on / 7-off second pattern
        power_sel = 4'd3;
        press_key(2); press_key(0);
        press_enter();
        power_sel = 4'd10;
        press_start();
        check("t2_load_val", {timer_min, timer_tens, timer_ones}, 12'h020);
        bad = 0; ons = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            exp_mag = ((i / 100) % 10) < 3;
            if (mag_on !== exp_mag) bad++;
            if (mag_on) ons++;
        end
        check("t2_mag_pattern_errs", bad, 0);
        check("t2_mag_on_cycles", ons, 400);
        @(negedge clock); timer_zero = 1'b1;
        @(negedge clock); timer_zero = 1'b0;
        check("t2_done_beep", beep, 1);
        press_stop();
        check("t2_stop_ends_beep", beep, 0);

        // Program 3: two stages, chaining, door pause/resume, stop flush
        press_key(5); press_enter();
        power_sel = 4'd5;
        press_key(1); press_key(0); press_enter();
        power_sel = 4'd10;
        check("t3_qcount", queue_count, 2);
        press_start();
        check("t3_first_load", {timer_load, timer_min, timer_tens, timer_ones}, 13'h1005);
        repeat (150) @(negedge clock);
        @(negedge clock); timer_zero = 1'b1;
        @(negedge clock); timer_zero = 1'b0;
        check("t3_second_load", timer_load, 1);
        check("t3_second_val", {timer_min, timer_tens, timer_ones}, 12'h010);
        check("t3_stage_idx", stage_idx, 1);
        check("t3_qcount_after_pop", queue_count, 1);
        ons = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clock);
            if (mag_on) ons++;
        end
        check("t3_window_reset_ons", ons, 250);
        @(negedge clock); door_closed = 1'b0; #1;
        check("t3_door_mag_off", mag_on, 0);
        @(negedge clock); door_closed = 1'b1; #1;
        check("t3_paused_mag_off", mag_on, 0);
        press_start();
        check("t3_resume_no_load", timer_load, 0);
        check("t3_resume_mag_on", mag_on, 1);
        press_stop();
        check("t3_stop1_mag_off", mag_on, 0);
        check("t3_stop1_qcount", queue_count, 1);
        press_stop();
        check("t3_stop2_qcount", queue_count, 0);
        @(negedge clock);
        check("t3_idle_no_load", timer_load, 0);

        // Queue limits: zero entry and overflow
        press_enter();
        check("t4_zero_push_err", push_err, 1);
        check("t4_zero_qcount", queue_count, 0);
        for (int i = 0; i < 4; i++) begin
            press_key(1); press_enter();
        end
        check("t4_full_qcount", queue_count, 4);
        check("t4_full_no_err", push_err, 0);
        press_key(2); press_enter();
        check("t4_overflow_err", push_err, 1);
        check("t4_overflow_qcount", queue_count, 4);
        check("t4_entry_kept", {timer_min, timer_tens, timer_ones}, 12'h002);
        @(negedge clock);
        check("t4_err_pulse_ends", push_err, 0);

        // Reset in the middle of cooking
        press_start();
        check("t5_load", timer_load, 1);
        repeat (150) @(negedge clock);
        check("t5_cooking", mag_on, 1);
        clearn = 1'b0; #1;
        check("t5_rst_mag", mag_on, 0);
        check("t5_rst_dec", timer_dec, 0);
        check("t5_rst_qcount", queue_count, 0);
        @(negedge clock); clearn = 1'b1;
        @(negedge clock);
        check("t5_idle_after", {timer_load, beep, timer_min, timer_tens, timer_ones}, 0);

        // Start with no queued stage auto-pushes the entry at power 10
        press_key(7);
        press_start();
        check("t6_auto_load", {timer_load, timer_min, timer_tens, timer_ones}, 13'h1007);
        check("t6_auto_qcount", queue_count, 1);
        @(negedge clock);
        check("t6_auto_mag", mag_on, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
